// File: rtl/acc_seq_pkg.sv
// Shared types and constants for the accumulation-phase sequencer.
package acc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        READ,
        DRAIN,
        RELU,
        EMIT,
        FIN
    } state_t;

    localparam int unsigned K_DEF     = 3;
    localparam int unsigned OUT_W_DEF = 8;
    localparam int unsigned OUT_H_DEF = 8;
    localparam int unsigned KK        = K_DEF * K_DEF;
    localparam int unsigned N_OUT     = OUT_W_DEF * OUT_H_DEF;

    localparam int unsigned ACC_BIT   = 33;
    localparam int unsigned CENP_BIT  = 32;
    localparam int unsigned WENP_BIT  = 31;
    localparam int unsigned APMEM_MSB = 30;
    localparam int unsigned APMEM_LSB = 20;
    localparam int unsigned RELU_BIT  = 5;

endpackage

// File: rtl/acc_addr_gen.sv
// Psum address generator: kernel (ki/kj) and output-pixel (orow/ocol) counters
// plus the address adder, no divider.
module acc_addr_gen
    import acc_seq_pkg::*;
#(
    parameter int unsigned OUT_W     = OUT_W_DEF,
    parameter int unsigned OUT_H     = OUT_H_DEF,
    parameter int unsigned IN_W      = 10,
    parameter int unsigned K         = K_DEF,
    parameter int unsigned LEN_NIJ   = 100,
    parameter int unsigned PSUM_BASE = 0,
    parameter int unsigned ADDR_BW   = 11
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               clr_i,
    input  logic                               step_i,
    input  logic                               next_out_i,
    output logic [ADDR_BW-1:0]                 a_pmem_o,
    output logic                               last_kij_o,
    output logic                               last_out_o,
    output logic [$clog2(OUT_W*OUT_H)-1:0]     out_idx_o
);

    localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int unsigned RW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int unsigned IW = $clog2(OUT_W * OUT_H);

    logic [KW-1:0]      ki_q, ki_d, kj_q, kj_d;
    logic [CW-1:0]      ocol_q, ocol_d;
    logic [RW-1:0]      orow_q, orow_d;
    logic [ADDR_BW-1:0] off_q, off_d;
    logic [IW-1:0]      idx_q, idx_d;

    always_comb begin
        ki_d   = ki_q;
        kj_d   = kj_q;
        off_d  = off_q;
        ocol_d = ocol_q;
        orow_d = orow_q;
        idx_d  = idx_q;
        if (clr_i) begin
            ki_d   = '0;
            kj_d   = '0;
            off_d  = '0;
            ocol_d = '0;
            orow_d = '0;
            idx_d  = '0;
        end else begin
            // off_q tracks kij*LEN_NIJ modulo 2^ADDR_BW
            if (step_i) begin
                if (kj_q == KW'(K - 1)) begin
                    kj_d = '0;
                    if (ki_q == KW'(K - 1)) begin
                        ki_d  = '0;
                        off_d = '0;
                    end else begin
                        ki_d  = ki_q + KW'(1);
                        off_d = off_q + ADDR_BW'(LEN_NIJ);
                    end
                end else begin
                    kj_d  = kj_q + KW'(1);
                    off_d = off_q + ADDR_BW'(LEN_NIJ);
                end
            end
            if (next_out_i) begin
                idx_d = idx_q + IW'(1);
                if (ocol_q == CW'(OUT_W - 1)) begin
                    ocol_d = '0;
                    orow_d = orow_q + RW'(1);
                end else begin
                    ocol_d = ocol_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ki_q   <= '0;
            kj_q   <= '0;
            off_q  <= '0;
            ocol_q <= '0;
            orow_q <= '0;
            idx_q  <= '0;
        end else begin
            ki_q   <= ki_d;
            kj_q   <= kj_d;
            off_q  <= off_d;
            ocol_q <= ocol_d;
            orow_q <= orow_d;
            idx_q  <= idx_d;
        end
    end

    always_comb begin
        a_pmem_o = ADDR_BW'(PSUM_BASE) + off_q
                 + ADDR_BW'((32'(orow_q) + 32'(ki_q)) * IN_W)
                 + ADDR_BW'(ocol_q) + ADDR_BW'(kj_q);
    end

    assign last_kij_o = (ki_q == KW'(K - 1)) && (kj_q == KW'(K - 1));
    assign last_out_o = (orow_q == RW'(OUT_H - 1)) && (ocol_q == CW'(OUT_W - 1));
    assign out_idx_o  = idx_q;

endmodule

// File: rtl/acc_sequencer.sv
// Accumulation-phase sequencer: per output pixel reads the K*K psums, pulses acc/relu
// and flags the result. Define ACC_SEQ_PERF_EN to add the perf_cycles busy counter.
module acc_sequencer
    import acc_seq_pkg::*;
#(
    parameter int unsigned OUT_W     = OUT_W_DEF,
    parameter int unsigned OUT_H     = OUT_H_DEF,
    parameter int unsigned IN_W      = 10,
    parameter int unsigned K         = K_DEF,
    parameter int unsigned LEN_NIJ   = 100,
    parameter int unsigned PSUM_BASE = 0,
    parameter int unsigned ADDR_BW   = 11
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    output logic                           busy,
    output logic                           done,
    output logic                           acc,
    output logic                           CEN_pmem,
    output logic                           WEN_pmem,
    output logic [ADDR_BW-1:0]             A_pmem,
    output logic                           relu,
    output logic                           sfp_clr,
    output logic                           out_valid,
    output logic [$clog2(OUT_W*OUT_H)-1:0] out_idx
`ifdef ACC_SEQ_PERF_EN
    ,
    output logic [15:0]                    perf_cycles
`endif
);

    localparam int unsigned IW = $clog2(OUT_W * OUT_H);

    state_t             state_q, state_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               cen_q, cen_d, acc_q, acc_d;
    logic               relu_q, relu_d, clr_q, clr_d, vld_q, vld_d;
    logic               last_rd_q, last_rd_d;
    logic [ADDR_BW-1:0] addr_q, addr_d, gen_addr;
    logic [IW-1:0]      idx_q, idx_d, gen_idx;
    logic               gen_last_kij, gen_last_out;
    logic               step, next_out, gen_clr;

    acc_addr_gen #(
        .OUT_W    (OUT_W),
        .OUT_H    (OUT_H),
        .IN_W     (IN_W),
        .K        (K),
        .LEN_NIJ  (LEN_NIJ),
        .PSUM_BASE(PSUM_BASE),
        .ADDR_BW  (ADDR_BW)
    ) u_addr_gen (
        .clk_i     (clk),
        .rst_ni    (reset),
        .clr_i     (gen_clr),
        .step_i    (step),
        .next_out_i(next_out),
        .a_pmem_o  (gen_addr),
        .last_kij_o(gen_last_kij),
        .last_out_o(gen_last_out),
        .out_idx_o (gen_idx)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !abort) state_d = CLEAR;
            CLEAR:   state_d = READ;
            READ:    if (last_rd_q) state_d = DRAIN;
            DRAIN:   state_d = RELU;
            RELU:    state_d = EMIT;
            EMIT:    state_d = gen_last_out ? FIN : CLEAR;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;

        // Outputs are registered from the next state; the generator is stepped as each
        // address is loaded, so last_rd_q marks the READ cycle that carries the final kij.
        step      = (state_d == READ);
        next_out  = (state_q == EMIT) && (state_d == CLEAR);
        gen_clr   = (state_d == IDLE);
        last_rd_d = step && gen_last_kij;

        busy_d = (state_d inside {CLEAR, READ, DRAIN, RELU, EMIT});
        done_d = (state_d == FIN);
        cen_d  = (state_d != READ);
        acc_d  = !cen_q && (state_d != IDLE);
        relu_d = (state_d == RELU);
        clr_d  = (state_d == CLEAR);
        vld_d  = (state_d == EMIT);
        addr_d = step ? gen_addr : '0;
        idx_d  = vld_d ? gen_idx : idx_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cen_q     <= 1'b1;
            acc_q     <= 1'b0;
            relu_q    <= 1'b0;
            clr_q     <= 1'b0;
            vld_q     <= 1'b0;
            last_rd_q <= 1'b0;
            addr_q    <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cen_q     <= cen_d;
            acc_q     <= acc_d;
            relu_q    <= relu_d;
            clr_q     <= clr_d;
            vld_q     <= vld_d;
            last_rd_q <= last_rd_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign acc       = acc_q;
    assign CEN_pmem  = cen_q;
    assign WEN_pmem  = 1'b1;
    assign A_pmem    = addr_q;
    assign relu      = relu_q;
    assign sfp_clr   = clr_q;
    assign out_valid = vld_q;
    assign out_idx   = idx_q;

`ifdef ACC_SEQ_PERF_EN
    logic [15:0] perf_q, perf_d;

    // Counts every non-IDLE cycle, including FIN and the cycle abort is seen.
    always_comb begin
        perf_d = perf_q;
        if (state_q == IDLE) begin
            if (start && !abort) perf_d = '0;
        end else if (perf_q != '1) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`endif

endmodule
